// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchroniser plus per-bit debounce with rise/fall strobes
module sw_debounce_sync #(
  parameter int WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHANGED
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, expire;
  logic [CNT_W-1:0] cnt [WIDTH];
  // two-flop chain bringing the raw switches into the clock domain
  always_ff @(posedge CLOCK_50) begin
    sync1 <= RESET ? '0 : SW;
    sync2 <= RESET ? '0 : sync1;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign expire[i] = (sync2[i] != SW_DB[i]) && (cnt[i] == LAST);
    // stability counter: cleared on agreement or expiry, otherwise counts the mismatch run
    always_ff @(posedge CLOCK_50)
      cnt[i] <= (RESET || sync2[i] == SW_DB[i] || expire[i]) ? '0 : cnt[i] + 1'b1;
  end
  // debounced level flips on expiry; strobes are registered alongside so they align with the flip
  always_ff @(posedge CLOCK_50) begin
    SW_DB      <= RESET ? '0 : SW_DB ^ expire;
    SW_RISE    <= RESET ? '0 : expire & sync2;
    SW_FALL    <= RESET ? '0 : expire & ~sync2;
    SW_CHANGED <= !RESET && |expire;
  end
endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: directed checks of sync latency, glitch rejection, strobes and reset
module tb_sw_debounce_sync;
  logic clk = 0;
  logic rst = 1;
  logic [9:0] sw = 10'h3FF;
  logic [9:0] sw_db, sw_rise, sw_fall;
  logic sw_changed;
  int total = 0;
  int bad = 0;
  int strobes = 0;

  sw_debounce_sync #(.WIDTH(10), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw),
    .SW_DB(sw_db), .SW_RISE(sw_rise), .SW_FALL(sw_fall), .SW_CHANGED(sw_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sw_changed) strobes++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    tick(1);
    chk("rst_db", sw_db, 0);
    chk("rst_rise", sw_rise, 0);
    tick(2);
    chk("rst_db3", sw_db, 0);
    chk("rst_chg3", sw_changed, 0);
    chk("rst_fall3", sw_fall, 0);
    rst = 0;
    tick(5);
    chk("rel_db5", sw_db, 0);
    chk("rel_chg5", sw_changed, 0);
    tick(1);
    chk("rel_db6", sw_db, 10'h3FF);
    chk("rel_rise6", sw_rise, 10'h3FF);
    chk("rel_fall6", sw_fall, 0);
    chk("rel_chg6", sw_changed, 1);
    tick(1);
    chk("rel_rise7", sw_rise, 0);
    chk("rel_chg7", sw_changed, 0);
    chk("rel_db7", sw_db, 10'h3FF);

    sw = 10'h000;
    tick(8);
    chk("clr_db", sw_db, 0);
    sw = 10'h005;
    tick(5);
    chk("clean_db5", sw_db, 0);
    tick(1);
    chk("clean_db6", sw_db, 10'h005);
    chk("clean_rise6", sw_rise, 10'h005);
    chk("clean_fall6", sw_fall, 0);
    chk("clean_chg6", sw_changed, 1);
    tick(1);
    chk("clean_rise7", sw_rise, 0);
    chk("clean_chg7", sw_changed, 0);

    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      sw = (k % 2 == 0) ? 10'h00D : 10'h005;
      tick(2);
    end
    tick(8);
    chk("bounce_db", sw_db, 10'h005);
    chk("bounce_strobes", strobes, 0);

    sw = 10'h00D; tick(1);
    sw = 10'h005; tick(1);
    sw = 10'h00D; tick(1);
    sw = 10'h005; tick(2);
    chk("settle_pre_strobes", strobes, 0);
    sw = 10'h00D;
    tick(5);
    chk("settle_db5", sw_db, 10'h005);
    tick(1);
    chk("settle_db6", sw_db, 10'h00D);
    chk("settle_rise6", sw_rise, 10'h008);
    chk("settle_chg6", sw_changed, 1);
    tick(6);
    chk("settle_strobes", strobes, 1);

    sw = 10'h0F0;
    tick(8);
    chk("pre_sim_db", sw_db, 10'h0F0);
    sw = 10'h00F;
    tick(5);
    chk("sim_db5", sw_db, 10'h0F0);
    tick(1);
    chk("sim_db6", sw_db, 10'h00F);
    chk("sim_rise6", sw_rise, 10'h00F);
    chk("sim_fall6", sw_fall, 10'h0F0);
    chk("sim_chg6", sw_changed, 1);
    tick(1);
    chk("sim_chg7", sw_changed, 0);
    chk("sim_rise7", sw_rise, 0);
    chk("sim_fall7", sw_fall, 0);

    strobes = 0;
    sw = 10'h20F;
    tick(2);
    rst = 1;
    tick(1);
    rst = 0;
    chk("mid_strobes", strobes, 0);
    chk("mid_db_rst", sw_db, 0);
    tick(5);
    chk("mid_db5", sw_db, 0);
    tick(1);
    chk("mid_db6", sw_db, 10'h20F);
    chk("mid_rise6", sw_rise, 10'h20F);
    chk("mid_chg6", sw_changed, 1);
    tick(1);

    sw = 10'h000;
    tick(5);
    chk("exp_db5", sw_db, 10'h20F);
    strobes = 0;
    rst = 1;
    tick(1);
    rst = 0;
    chk("exp_db", sw_db, 0);
    chk("exp_fall", sw_fall, 0);
    chk("exp_chg", sw_changed, 0);
    tick(8);
    chk("exp_strobes", strobes, 0);
    chk("exp_db_end", sw_db, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
